// File: rtl/ddr_cmd_sched.sv
// ddr_cmd_sched: merges the TinyComp command stream (buffered in a small FIFO),
// the handshaked host requester and periodic refresh obligations onto one
// valid/ready command port feeding the DDR2 controller.
module ddr_cmd_sched #(
  parameter int          FIFO_DEPTH = 4,    // power of 2, >= 2
  parameter int          REF_MAX    = 8,    // pending-refresh saturation, <= 15
  parameter int          REF_URGENT = 6,    // 1 <= REF_URGENT <= REF_MAX
  parameter logic [2:0]  REF_CMD    = 3'd1  // refresh opcode in bits [30:28]
) (
  input  logic        Ph0,
  input  logic        ResetN,
  input  logic        tcInject,
  input  logic [33:0] tcCmd,
  input  logic        hostValid,
  input  logic [33:0] hostCmd,
  output logic        hostReady,
  input  logic        refTick,
  input  logic        inhibit,
  output logic        cmdValid,
  output logic [33:0] cmd,
  output logic [1:0]  cmdSrc,
  input  logic        cmdReady,
  output logic        tcOverflow,
  output logic        refMissed,
  output logic [3:0]  refPending
);

  localparam int         PTR_W      = $clog2(FIFO_DEPTH);
  localparam int         CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL_V = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0] REF_MAX_V  = 4'(REF_MAX);
  localparam logic [3:0] REF_URG_V  = 4'(REF_URGENT);
  localparam logic [33:0] REF_WORD  = {3'b000, REF_CMD, 28'h0000000};

  // Source encoding doubles as the cmdSrc output code.
  typedef enum logic [1:0] {
    SRC_TC   = 2'd0,
    SRC_HOST = 2'd1,
    SRC_REF  = 2'd2,
    SRC_NONE = 2'd3
  } src_e;

  // TC FIFO storage and bookkeeping
  logic [33:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Scheduler state
  logic [3:0]  r_ref_pend;
  logic        r_tc_ovf;
  logic        r_ref_miss;
  logic        r_valid;
  logic [33:0] r_cmd;
  logic [1:0]  r_src;
  logic        r_prefer_host;  // round-robin: 1 when host should win a tie

  // Combinational decisions
  logic        w_free;
  logic        w_load_en;
  logic        w_tc_avail;
  logic        w_urgent;
  src_e        w_sel;
  logic        w_load;
  logic        w_pop;
  logic        w_push;
  logic        w_ref_load;
  logic [33:0] w_load_word;

  assign w_free     = ~r_valid | cmdReady;
  assign w_load_en  = w_free & ~inhibit;
  assign w_tc_avail = (r_count != '0);
  assign w_urgent   = (r_ref_pend >= REF_URG_V);

  // Priority select: urgent refresh, then TC/host round-robin, then refresh.
  // NOTE: every variable of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sel = SRC_NONE;
    if (w_urgent) begin
      w_sel = SRC_REF;
    end else if (w_tc_avail && hostValid) begin
      w_sel = r_prefer_host ? SRC_HOST : SRC_TC;
    end else if (w_tc_avail) begin
      w_sel = SRC_TC;
    end else if (hostValid) begin
      w_sel = SRC_HOST;
    end else if (r_ref_pend != 4'd0) begin
      w_sel = SRC_REF;
    end
  end

  // Word presented to the output register for the selected source.
  always_comb begin
    w_load_word = '0;
    case (w_sel)
      SRC_TC:   w_load_word = r_mem[r_rd_ptr];
      SRC_HOST: w_load_word = hostCmd;
      SRC_REF:  w_load_word = REF_WORD;
      default:  w_load_word = '0;
    endcase
  end

  assign w_load     = w_load_en & (w_sel != SRC_NONE);
  assign w_pop      = w_load & (w_sel == SRC_TC);
  assign w_ref_load = w_load & (w_sel == SRC_REF);
  // A full FIFO still takes the strobe when its head leaves in the same cycle.
  assign w_push     = tcInject & ((r_count < FIFO_FULL_V) | w_pop);

  // Host is only acknowledged outside reset and when it owns the load slot.
  assign hostReady  = ResetN & w_load_en & (w_sel == SRC_HOST);

  // FIFO data array is written on push only.
  // NOTE: the storage array has no reset; its contents are only ever read
  // behind a non-zero count, and clearing the count discards them.
  always_ff @(posedge Ph0) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tcCmd;
    end
  end

  // FIFO pointers and occupancy.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the clock edge, independent of statement order.
  always_ff @(posedge Ph0 or negedge ResetN) begin
    if (!ResetN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Pending-refresh counter: ticks add, refresh loads subtract, both cancel.
  always_ff @(posedge Ph0 or negedge ResetN) begin
    if (!ResetN) begin
      r_ref_pend <= 4'd0;
      r_ref_miss <= 1'b0;
    end else if (refTick && !w_ref_load) begin
      if (r_ref_pend == REF_MAX_V) r_ref_miss <= 1'b1;
      else                         r_ref_pend <= r_ref_pend + 4'd1;
    end else if (w_ref_load && !refTick) begin
      r_ref_pend <= r_ref_pend - 4'd1;
    end
  end

  // Sticky flag for TC strobes that found no room.
  always_ff @(posedge Ph0 or negedge ResetN) begin
    if (!ResetN) begin
      r_tc_ovf <= 1'b0;
    end else if (tcInject && !w_push) begin
      r_tc_ovf <= 1'b1;
    end
  end

  // Round-robin pointer moves only when TC or host is actually loaded.
  always_ff @(posedge Ph0 or negedge ResetN) begin
    if (!ResetN) begin
      r_prefer_host <= 1'b0;
    end else if (w_load && (w_sel == SRC_TC)) begin
      r_prefer_host <= 1'b1;
    end else if (w_load && (w_sel == SRC_HOST)) begin
      r_prefer_host <= 1'b0;
    end
  end

  // Output stage: load when free and not inhibited; otherwise drop valid once
  // the held word is accepted. A stalled word is never modified.
  always_ff @(posedge Ph0 or negedge ResetN) begin
    if (!ResetN) begin
      r_valid <= 1'b0;
      r_cmd   <= '0;
      r_src   <= 2'd0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_cmd   <= w_load_word;
      r_src   <= w_sel;
    end else if (cmdReady) begin
      r_valid <= 1'b0;
    end
  end

  assign cmdValid   = r_valid;
  assign cmd        = r_cmd;
  assign cmdSrc     = r_src;
  assign tcOverflow = r_tc_ovf;
  assign refMissed  = r_ref_miss;
  assign refPending = r_ref_pend;

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Self-checking bench for ddr_cmd_sched: directed scenarios followed by a
// random phase, all compared against a queue-based reference model.
module tb_ddr_cmd_sched;

  localparam int          FIFO_DEPTH = 4;
  localparam int          REF_MAX    = 8;
  localparam int          REF_URGENT = 6;
  localparam logic [33:0] REF_WORD   = 34'h0_1000_0000;

  logic        Ph0;
  logic        ResetN;
  logic        tcInject;
  logic [33:0] tcCmd;
  logic        hostValid;
  logic [33:0] hostCmd;
  logic        hostReady;
  logic        refTick;
  logic        inhibit;
  logic        cmdValid;
  logic [33:0] cmd;
  logic [1:0]  cmdSrc;
  logic        cmdReady;
  logic        tcOverflow;
  logic        refMissed;
  logic [3:0]  refPending;

  int n_tests = 0;
  int n_fail  = 0;

  ddr_cmd_sched #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .REF_MAX    (REF_MAX),
    .REF_URGENT (REF_URGENT),
    .REF_CMD    (3'd1)
  ) dut (
    .Ph0        (Ph0),
    .ResetN     (ResetN),
    .tcInject   (tcInject),
    .tcCmd      (tcCmd),
    .hostValid  (hostValid),
    .hostCmd    (hostCmd),
    .hostReady  (hostReady),
    .refTick    (refTick),
    .inhibit    (inhibit),
    .cmdValid   (cmdValid),
    .cmd        (cmd),
    .cmdSrc     (cmdSrc),
    .cmdReady   (cmdReady),
    .tcOverflow (tcOverflow),
    .refMissed  (refMissed),
    .refPending (refPending)
  );

  initial Ph0 = 1'b0;
  always #5 Ph0 = ~Ph0;

  // Reference model: TC words waiting, refreshes owed, the held command.
  logic [33:0] m_q[$];
  int          m_ref;
  bit          m_ovf;
  bit          m_miss;
  bit          m_valid;
  logic [33:0] m_cmd;
  logic [1:0]  m_src;
  bit          m_last_host;

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_ref       = 0;
    m_ovf       = 0;
    m_miss      = 0;
    m_valid     = 0;
    m_cmd       = '0;
    m_src       = 2'd0;
    m_last_host = 1;  // TC is favoured first after reset
  endfunction

  // Which source would be served now: 0 TC, 1 host, 2 refresh, 3 nothing.
  function automatic int m_pick();
    bit tc;
    tc = (m_q.size() > 0);
    if (m_ref >= REF_URGENT) return 2;
    if (tc && hostValid)     return m_last_host ? 0 : 1;
    if (tc)                  return 0;
    if (hostValid)           return 1;
    if (m_ref > 0)           return 2;
    return 3;
  endfunction

  // One clock cycle: check hostReady, advance the model, check outputs.
  task automatic tick();
    bit          can_load;
    bit          ref_load;
    int          ch;
    int          sz;
    logic [33:0] word;
    #1;
    can_load = (!m_valid || cmdReady) && !inhibit;
    ch = m_pick();
    check("hostReady", 34'(hostReady), 34'(can_load && ch == 1));
    sz   = m_q.size();
    word = '0;
    if (can_load && ch != 3) begin
      case (ch)
        0:       begin word = m_q.pop_front(); m_last_host = 0; end
        1:       begin word = hostCmd;         m_last_host = 1; end
        default: word = REF_WORD;
      endcase
    end
    if (tcInject) begin
      if (sz < FIFO_DEPTH || (can_load && ch == 0)) m_q.push_back(tcCmd);
      else m_ovf = 1;
    end
    ref_load = can_load && ch == 2;
    if (refTick && !ref_load) begin
      if (m_ref == REF_MAX) m_miss = 1;
      else m_ref++;
    end else if (ref_load && !refTick) begin
      m_ref--;
    end
    if (can_load && ch != 3) begin
      m_valid = 1;
      m_cmd   = word;
      m_src   = 2'(ch);
    end else if (cmdReady) begin
      m_valid = 0;
    end
    @(posedge Ph0);
    #1;
    check("cmdValid",   34'(cmdValid),   34'(m_valid));
    check("tcOverflow", 34'(tcOverflow), 34'(m_ovf));
    check("refMissed",  34'(refMissed),  34'(m_miss));
    check("refPending", 34'(refPending), 34'(m_ref));
    if (m_valid) begin
      check("cmd",    cmd,           m_cmd);
      check("cmdSrc", 34'(cmdSrc),   34'(m_src));
    end
  endtask

  // Let all outstanding work drain with the controller always ready.
  task automatic drain();
    tcInject  = 0;
    hostValid = 0;
    refTick   = 0;
    inhibit   = 0;
    cmdReady  = 1;
    for (int k = 0; k < 40 && (m_q.size() != 0 || m_valid || m_ref != 0); k++) tick();
    check("drain_idle", 34'(cmdValid), 34'(0));
  endtask

  logic [33:0] words [6];

  initial begin
    ResetN    = 0;
    tcInject  = 0;
    tcCmd     = '0;
    hostValid = 1;
    hostCmd   = 34'h3_dead_beef;
    refTick   = 0;
    inhibit   = 0;
    cmdReady  = 1;
    model_reset();

    // Reset state, with a host request pending that must not be acknowledged.
    repeat (2) @(posedge Ph0);
    #1;
    check("rst_hostReady",  34'(hostReady),  34'(0));
    check("rst_cmdValid",   34'(cmdValid),   34'(0));
    check("rst_cmd",        cmd,             34'(0));
    check("rst_cmdSrc",     34'(cmdSrc),     34'(0));
    check("rst_refPending", 34'(refPending), 34'(0));
    check("rst_tcOverflow", 34'(tcOverflow), 34'(0));
    check("rst_refMissed",  34'(refMissed),  34'(0));
    ResetN    = 1;
    hostValid = 0;

    // Single TC injection: visible two cycles later.
    tcInject = 1;
    tcCmd    = 34'h1_2345_6000;
    tick();
    tcInject = 0;
    check("tc_lat_n1_valid", 34'(cmdValid), 34'(0));
    tick();
    check("tc_lat_n2_valid", 34'(cmdValid), 34'(1));
    check("tc_lat_n2_cmd",   cmd,           34'h1_2345_6000);
    check("tc_lat_n2_src",   34'(cmdSrc),   34'(0));
    check("tc_lat_n2_ref",   34'(refPending), 34'(0));
    drain();

    // Six strobes into a stalled port: one held, four buffered, one dropped.
    cmdReady = 0;
    for (int i = 0; i < 6; i++) begin
      words[i] = 34'h2_0000_0000 + 34'(i * 17 + 1);
      tcInject = 1;
      tcCmd    = words[i];
      tick();
    end
    tcInject = 0;
    check("ovf_set",     34'(tcOverflow), 34'(1));
    check("ovf_head",    cmd,             words[0]);
    cmdReady = 1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check("ovf_order_valid", 34'(cmdValid), 34'(1));
      check("ovf_order_cmd",   cmd,           words[i]);
    end
    tick();
    check("ovf_empty",  34'(cmdValid),   34'(0));
    check("ovf_sticky", 34'(tcOverflow), 34'(1));
    drain();

    // TC and host both continuously present: sources alternate.
    hostValid = 1;
    tcInject  = 1;
    for (int i = 0; i < 8; i++) begin
      tcCmd   = 34'h0_4000_0000 + 34'(i);
      hostCmd = 34'h0_8000_0000 + 34'(i);
      tick();
      check("rr_src", 34'(cmdSrc), 34'((i % 2 == 0) ? 1 : 0));
    end
    drain();

    // Urgent refresh preempts stalled TC/host traffic, then traffic resumes.
    cmdReady = 0;
    tcInject = 1;
    tcCmd    = 34'h0_0000_00aa;
    tick();
    tcCmd     = 34'h0_0000_00bb;
    hostValid = 1;
    hostCmd   = 34'h0_0000_00cc;
    tick();
    tcInject = 0;
    refTick  = 1;
    repeat (6) tick();
    refTick = 0;
    check("urg_pending6", 34'(refPending), 34'(6));
    cmdReady = 1;
    tick();
    check("urg_ref_cmd",  cmd,             REF_WORD);
    check("urg_ref_src",  34'(cmdSrc),     34'(2));
    check("urg_pending5", 34'(refPending), 34'(5));
    tick();
    check("urg_resume_valid",  34'(cmdValid),        34'(1));
    check("urg_resume_notref", 34'(cmdSrc == 2'd2),  34'(0));
    drain();

    // Saturation under inhibit, then back-to-back refreshes.
    inhibit = 1;
    refTick = 1;
    repeat (9) tick();
    refTick = 0;
    check("sat_pending", 34'(refPending), 34'(8));
    check("sat_missed",  34'(refMissed),  34'(1));
    check("sat_novalid", 34'(cmdValid),   34'(0));
    inhibit = 0;
    for (int i = 0; i < 8; i++) begin
      refTick = (i == 3);
      tick();
      check("sat_issue_valid", 34'(cmdValid), 34'(1));
      check("sat_issue_src",   34'(cmdSrc),   34'(2));
      if (i == 3) check("sat_tick_and_load", 34'(refPending), 34'(5));
    end
    refTick = 0;
    drain();

    // Reset in the middle of a stall with buffered TC words.
    cmdReady = 0;
    tcInject = 1;
    for (int i = 0; i < 3; i++) begin
      tcCmd = 34'h1_0000_0f00 + 34'(i);
      tick();
    end
    tcInject = 0;
    tick();
    check("rstmid_pre_valid", 34'(cmdValid), 34'(1));
    hostValid = 1;
    #2;
    ResetN = 0;
    #1;
    check("rstmid_cmdValid",   34'(cmdValid),   34'(0));
    check("rstmid_cmd",        cmd,             34'(0));
    check("rstmid_cmdSrc",     34'(cmdSrc),     34'(0));
    check("rstmid_refPending", 34'(refPending), 34'(0));
    check("rstmid_tcOverflow", 34'(tcOverflow), 34'(0));
    check("rstmid_refMissed",  34'(refMissed),  34'(0));
    check("rstmid_hostReady",  34'(hostReady),  34'(0));
    model_reset();
    @(posedge Ph0);
    #1;
    ResetN    = 1;
    hostValid = 0;
    cmdReady  = 1;
    repeat (4) tick();
    check("rstmid_no_stale", 34'(cmdValid), 34'(0));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      tcInject  = ($urandom_range(0, 99) < 30);
      tcCmd     = {2'($urandom), 32'($urandom)};
      hostValid = ($urandom_range(0, 99) < 40);
      hostCmd   = {2'($urandom), 32'($urandom)};
      refTick   = ($urandom_range(0, 99) < 12);
      inhibit   = ($urandom_range(0, 99) < 10);
      cmdReady  = ($urandom_range(0, 99) < 65);
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_sched.md
# ddr_cmd_sched

Command scheduler in front of the DDR2 memory controller. It merges three command sources onto one valid/ready command port: TinyComp's fire-and-forget `injectTC5address`/`LastALU` stream, a second handshaked requester (the host/test path), and periodic refresh ticks. TC commands are buffered in a small FIFO because the TC has no backpressure. Refresh obligations are counted and escalated to top priority when they become urgent.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: TC command FIFO depth; must be a power of 2, at least 2.
- `REF_MAX`, 8: saturation limit of the pending-refresh counter.
- `REF_URGENT`, 6: pending count at or above which refresh preempts all other sources; must satisfy 1 ≤ `REF_URGENT` ≤ `REF_MAX`.
- `REF_CMD`, 3'd1: cmd field code for refresh, placed in bits [30:28] of the refresh command word.

Ports:
- `Ph0` in 1: clock.
- `ResetN` in 1: asynchronous, active-low reset.
- `tcInject` in 1: one-cycle strobe (TC `injectTC5address`).
- `tcCmd` in 34: TC command word (`LastALU`), sampled when `tcInject`=1.
- `hostValid` in 1: host request valid.
- `hostCmd` in 34: host command word.
- `hostReady` out 1: combinational; host word is taken this cycle when `hostValid`&`hostReady`.
- `refTick` in 1: one-cycle pulse, one refresh interval elapsed.
- `inhibit` in 1: level (`InhibitDDR`); while high, no new command is loaded.
- `cmdValid` out 1: output command valid.
- `cmd` out 34: output command word.
- `cmdSrc` out 2: source of `cmd`; 0=TC, 1=host, 2=refresh.
- `cmdReady` in 1: controller accepts `cmd` when `cmdValid`&`cmdReady`.
- `tcOverflow` out 1: sticky; a TC strobe was dropped.
- `refMissed` out 1: sticky; `refTick` arrived with the counter already at `REF_MAX`.
- `refPending` out 4: refreshes not yet loaded into the output stage.

## Operation
- Reset (asynchronous, `ResetN`=0) clears everything: `cmdValid`=0, `cmd`=0, `cmdSrc`=0, FIFO empty, `refPending`=0, `tcOverflow`=0, `refMissed`=0, round-robin pointer favours TC. `hostReady`=0 while in reset. Reset mid-handshake discards the held command and all FIFO contents.
- TC FIFO push:
  - On `tcInject`, push `tcCmd` if count < `FIFO_DEPTH`, or if count = `FIFO_DEPTH` and a pop happens in the same cycle.
  - Otherwise drop the word and set `tcOverflow`.
- Refresh counter:
  - `refTick` adds +1; the counter saturates at `REF_MAX`. A tick arriving at `REF_MAX` sets `refMissed`.
  - Loading a refresh into the output stage subtracts 1.
  - A tick and a load in the same cycle give a net change of 0, and do not set `refMissed`.
- Output stage: a single register. Define `free` = (~`cmdValid` | `cmdReady`). When `free` & ~`inhibit`, load the highest-priority candidate below; if there is no candidate and `cmdReady` is high, clear `cmdValid`.
  1. Refresh, if `refPending` ≥ `REF_URGENT`.
  2. TC FIFO head vs. host (`hostValid`), round-robin. With both present, the one not served last wins. The pointer updates only when one of these two is loaded.
  3. Refresh, if `refPending` > 0.
- Refresh word is {3'b0, `REF_CMD`, 28'b0}.
- `hostReady` = `free` & ~`inhibit` & host selected. It never asserts while `hostValid`=0.
- `inhibit`:
  - Blocks new loads only.
  - A command already held stays valid and unchanged until accepted; it is never retracted.
  - A held command accepted during `inhibit` clears `cmdValid`.
- While `cmdValid`=1 and `cmdReady`=0, `cmd`/`cmdSrc` are stable.

## Timing
- TC: `tcInject` at cycle n → earliest `cmdValid` at n+2 (FIFO write, then load).
- Host: handshake at cycle n → `cmdValid` at n+1.
- Refresh: urgent threshold crossed by `refTick` at n → refresh `cmdValid` at n+2 (counter update, then load).
- Throughput is one command per cycle with `cmdReady` held high. Accept and reload in the same cycle creates no bubble.
- No combinational path from `cmdReady` to `cmd`. `hostReady` depends combinationally on `cmdReady`, `cmdValid`, `inhibit`, `hostValid`, FIFO empty, `refPending` and the pointer.

## Test plan
- Idle, `cmdReady`=1; one `tcInject` with `tcCmd`=34'h1_2345_6000 at cycle 0 → `cmdValid` cycle 2, `cmd`=34'h1_2345_6000, `cmdSrc`=0, `refPending`=0.
- `cmdReady`=0; 6 consecutive `tcInject` strobes → FIFO holds 4 words plus 1 in the output stage. The 6th strobe is dropped and `tcOverflow`=1 (stays 1). Release `cmdReady` → 5 words delivered in order, back-to-back.
- TC FIFO and `hostValid` continuously non-empty, `cmdReady`=1 → `cmdSrc` alternates 0,1,0,1…
- 6 `refTick` pulses with `cmdReady`=0 and TC/host traffic pending; raise `cmdReady` → the next loads are refreshes until `refPending`=5. The refresh `cmd` equals 34'h0_1000_0000 with `REF_CMD`=1. TC/host traffic then resumes.
- 9 `refTick` pulses with `inhibit`=1 → `refPending`=8, `refMissed`=1, `cmdValid` stays 0. Drop `inhibit` → 8 refreshes issue. A same-cycle `refTick`+load leaves the count unchanged.
- Assert `ResetN`=0 mid-stall with `cmdValid`=1 and the FIFO non-empty → all outputs go to 0 immediately. After release, no stale command appears.
